rvga_mem_arbiter: RTL

Shared-memory arbiter between the L1 instruction cache and L1 data cache miss ports and the single DDR line port. It sits directly downstream of the core's two `l1cache` DDR interfaces (`icache_iddr_*`, `dcache_dddr_*`). It serialises whole-cacheline transactions onto one DDR port with round-robin fairness, registered request and response paths, and a DDR-response watchdog.

---
 rtl/rvga_mem_arbiter_pkg.sv | 22 ++
 rtl/rvga_arb_watchdog.sv | 48 ++++
 rtl/rvga_mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rvga_mem_arbiter_pkg.sv
// Shared types for the L1-to-DDR memory arbiter: word/line types, FSM states
// and requester identities.
package rvga_mem_arbiter_pkg;

    localparam int LINE_BITS = 256;
    localparam int WDOG_BITS = 16;

    typedef logic [31:0]          rvga_word;
    typedef logic [LINE_BITS-1:0] rvga_cacheline;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rvga_arb_state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } rvga_arb_owner_e;

endpackage

// File: rtl/rvga_arb_watchdog.sv
// DDR response watchdog: counts stalled WAIT cycles and raises a sticky flag
// once the count reaches TIMEOUT_CYCLES. Never aborts the transaction.
module rvga_arb_watchdog
    import rvga_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic timeout_o
);

    localparam logic [WDOG_BITS-1:0] LIMIT_M1 = 16'(TIMEOUT_CYCLES - 1);

    logic [WDOG_BITS-1:0] count_q, count_d;
    logic                 flag_q, flag_d;

    // Flag sets on the same edge the counter reaches the limit; counter saturates.
    always_comb begin
        count_d = count_q;
        flag_d  = flag_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
            if (count_q == LIMIT_M1) begin
                flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign timeout_o = flag_q;

endmodule

// File: rtl/rvga_mem_arbiter.sv
// Round-robin arbiter serialising icache and dcache line transactions onto a
// single DDR line port; all outputs come from registers or the FSM state.
module rvga_mem_arbiter
    import rvga_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          icache_iddr_addr,
    input  logic                 icache_iddr_read,
    output logic [LINE_BITS-1:0] iddr_icache_rdata,
    output logic                 iddr_icache_resp,
    input  logic [31:0]          dcache_dddr_addr,
    input  logic                 dcache_dddr_read,
    input  logic                 dcache_dddr_write,
    input  logic [LINE_BITS-1:0] dcache_dddr_wdata,
    output logic [LINE_BITS-1:0] dddr_dcache_rdata,
    output logic                 dddr_dcache_resp,
    output logic [31:0]          arb_ddr_addr,
    output logic                 arb_ddr_read,
    output logic                 arb_ddr_write,
    output logic [LINE_BITS-1:0] arb_ddr_wdata,
    input  logic [LINE_BITS-1:0] ddr_arb_rdata,
    input  logic                 ddr_arb_resp,
    output logic                 arb_timeout
);

    rvga_arb_state_e state_q, state_d;
    rvga_arb_owner_e owner_q, owner_d, last_grant_q, last_grant_d, grant_owner;
    rvga_word        addr_q, addr_d;
    logic            write_q, write_d;
    rvga_cacheline   wdata_q, wdata_d;
    rvga_cacheline   irdata_q, irdata_d, drdata_q, drdata_d;
    logic            i_req, d_req, grant;
    logic            wd_en, wd_clr;

    assign i_req = icache_iddr_read;
    assign d_req = dcache_dddr_read | dcache_dddr_write;
    // On a tie the requester that did not win last time is served.
    assign grant_owner = (d_req && (!i_req || last_grant_q == ICACHE)) ? DCACHE : ICACHE;
    assign grant = (state_q == IDLE) && (i_req || d_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req || d_req) state_d = WAIT;
            WAIT:    if (ddr_arb_resp)   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arb_ddr_read     = (state_q == WAIT) && !write_q;
        arb_ddr_write    = (state_q == WAIT) && write_q;
        iddr_icache_resp = (state_q == RESP) && (owner_q == ICACHE);
        dddr_dcache_resp = (state_q == RESP) && (owner_q == DCACHE);
        wd_en            = (state_q == WAIT) && !ddr_arb_resp;
        wd_clr           = grant;
    end

    // Transaction capture at grant; a simultaneous dcache read+write is a writeback.
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        irdata_d     = irdata_q;
        drdata_d     = drdata_q;
        if (grant) begin
            owner_d      = grant_owner;
            last_grant_d = grant_owner;
            addr_d       = (grant_owner == DCACHE) ? dcache_dddr_addr : icache_iddr_addr;
            write_d      = (grant_owner == DCACHE) && dcache_dddr_write;
            if ((grant_owner == DCACHE) && dcache_dddr_write) begin
                wdata_d = dcache_dddr_wdata;
            end
        end
        if ((state_q == WAIT) && ddr_arb_resp && !write_q) begin
            if (owner_q == ICACHE) begin
                irdata_d = ddr_arb_rdata;
            end else begin
                drdata_d = ddr_arb_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= ICACHE;
            last_grant_q <= DCACHE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            irdata_q     <= '0;
            drdata_q     <= '0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            irdata_q     <= irdata_d;
            drdata_q     <= drdata_d;
        end
    end

    assign arb_ddr_addr      = addr_q;
    assign arb_ddr_wdata     = wdata_q;
    assign iddr_icache_rdata = irdata_q;
    assign dddr_dcache_rdata = drdata_q;

    rvga_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .en_i      (wd_en),
        .clr_i     (wd_clr),
        .timeout_o (arb_timeout)
    );

endmodule
